// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bundle widths, field offsets,
// memory access size codes and the EX->MEM bundle layout.
package pipe_pkg;

  localparam int EX_TO_MEM_W = 107;
  localparam int MEM_TO_WB_W = 70;

  localparam int EM_PC_LSB   = 75;
  localparam int EM_ALU_LSB  = 43;
  localparam int EM_RKD_LSB  = 11;
  localparam int EM_DEST_LSB = 6;
  localparam int EM_GRWE_BIT = 5;
  localparam int EM_RFM_BIT  = 4;
  localparam int EM_MWE_BIT  = 3;
  localparam int EM_SIZE_LSB = 1;
  localparam int EM_UNS_BIT  = 0;

  localparam logic [1:0] MS_BYTE = 2'd0;
  localparam logic [1:0] MS_HALF = 2'd1;
  localparam logic [1:0] MS_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rkd;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_mem;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
  } mem_wb_t;

  function automatic logic [3:0] store_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    unique case (1'b1)
      size == MS_BYTE: m = 4'b0001 << off;
      size == MS_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default:         m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half out of the
// SRAM word and sign- or zero-extends it; words pass through.
module mem_load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] result
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;

  assign sh_b = rdata >> {addr, 3'b000};
  assign sh_h = rdata >> {addr[1], 4'b0000};

  always_comb begin
    result = rdata;
    unique case (1'b1)
      mem_size == MS_BYTE:
        result = {{24{~mem_unsigned & sh_b[7]}}, sh_b[7:0]};
      mem_size == MS_HALF:
        result = {{16{~mem_unsigned & sh_h[15]}}, sh_h[15:0]};
      default:
        result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues SRAM requests on accept, captures and aligns
// load data the next cycle, and holds it steady across WB stalls.
module mem_stage #(
  parameter int          EX_TO_MEM_W = pipe_pkg::EX_TO_MEM_W,
  parameter int          MEM_TO_WB_W = pipe_pkg::MEM_TO_WB_W,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   EX_to_MEM_valid,
  input  logic [EX_TO_MEM_W-1:0] to_MEM_data,
  output logic                   MEM_allow_in,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   WB_allow_in,
  output logic                   MEM_to_WB_valid,
  output logic [MEM_TO_WB_W-1:0] to_WB_data,
  output logic [4:0]             MEM_dest,
  output logic                   MEM_is_load,
  output logic [31:0]            MEM_fwd_data
);

  import pipe_pkg::*;

  ex_mem_t     ex_in;
  ex_mem_t     held;
  mem_wb_t     wb_out;
  logic        mem_valid;
  logic        accept;
  logic        buf_vld;
  logic [31:0] rdata_buf;
  logic [31:0] load_word;
  logic [31:0] load_ext;
  logic [31:0] final_result;
  logic [31:0] rkd;

  assign ex_in.pc           = to_MEM_data[EM_PC_LSB +: 32];
  assign ex_in.alu          = to_MEM_data[EM_ALU_LSB +: 32];
  assign ex_in.rkd          = to_MEM_data[EM_RKD_LSB +: 32];
  assign ex_in.dest         = to_MEM_data[EM_DEST_LSB +: 5];
  assign ex_in.gr_we        = to_MEM_data[EM_GRWE_BIT];
  assign ex_in.res_from_mem = to_MEM_data[EM_RFM_BIT];
  assign ex_in.mem_we       = to_MEM_data[EM_MWE_BIT];
  assign ex_in.mem_size     = to_MEM_data[EM_SIZE_LSB +: 2];
  assign ex_in.mem_unsigned = to_MEM_data[EM_UNS_BIT];

  assign MEM_allow_in    = ~mem_valid | WB_allow_in;
  assign accept          = EX_to_MEM_valid & MEM_allow_in;
  assign MEM_to_WB_valid = mem_valid;

  assign rkd            = ex_in.rkd;
  assign data_sram_addr = ex_in.alu;
  assign data_sram_en   = accept & ~reset
                        & (ex_in.res_from_mem | ex_in.mem_we);
  assign data_sram_we   = (accept & ~reset & ex_in.mem_we)
                        ? store_mask(ex_in.mem_size, ex_in.alu[1:0])
                        : 4'b0000;

  always_comb begin
    data_sram_wdata = rkd;
    unique case (1'b1)
      ex_in.mem_size == MS_BYTE: data_sram_wdata = {4{rkd[7:0]}};
      ex_in.mem_size == MS_HALF: data_sram_wdata = {2{rkd[15:0]}};
      default:                   data_sram_wdata = rkd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      buf_vld   <= 1'b0;
      rdata_buf <= 32'h0;
      held      <= '0;
      held.pc   <= RESET_PC;
    end else begin
      if (MEM_allow_in) mem_valid <= EX_to_MEM_valid;
      if (accept) begin
        held    <= ex_in;
        buf_vld <= 1'b0;
      end else if (mem_valid & ~WB_allow_in & ~buf_vld) begin
        // SRAM output is only good for one cycle; keep it for the stall
        rdata_buf <= data_sram_rdata;
        buf_vld   <= 1'b1;
      end
    end
  end

  assign load_word = buf_vld ? rdata_buf : data_sram_rdata;

  mem_load_align u_align (
    .rdata        (load_word),
    .addr         (held.alu[1:0]),
    .mem_size     (held.mem_size),
    .mem_unsigned (held.mem_unsigned),
    .result       (load_ext)
  );

  assign final_result = held.res_from_mem ? load_ext : held.alu;

  assign wb_out.pc     = held.pc;
  assign wb_out.result = final_result;
  assign wb_out.dest   = held.dest;
  assign wb_out.gr_we  = held.gr_we;
  assign to_WB_data    = wb_out;

  assign MEM_dest     = (mem_valid & held.gr_we) ? held.dest : 5'd0;
  assign MEM_is_load  = mem_valid & held.res_from_mem;
  assign MEM_fwd_data = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-level reference memory,
// randomized loads/stores/ALU ops and random WB back-pressure.
module tb_mem_stage;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         EX_to_MEM_valid;
  logic [106:0] to_MEM_data;
  logic         MEM_allow_in;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [31:0]  data_sram_rdata;
  logic         WB_allow_in;
  logic         MEM_to_WB_valid;
  logic [69:0]  to_WB_data;
  logic [4:0]   MEM_dest;
  logic         MEM_is_load;
  logic [31:0]  MEM_fwd_data;

  mem_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_MEM_valid (EX_to_MEM_valid),
    .to_MEM_data     (to_MEM_data),
    .MEM_allow_in    (MEM_allow_in),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .WB_allow_in     (WB_allow_in),
    .MEM_to_WB_valid (MEM_to_WB_valid),
    .to_WB_data      (to_WB_data),
    .MEM_dest        (MEM_dest),
    .MEM_is_load     (MEM_is_load),
    .MEM_fwd_data    (MEM_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [69:0] wb;
    logic        is_load;
    logic [4:0]  dest;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_pct = 0;
  int          force_stall = 0;
  logic [31:0] sram[16];
  logic [7:0]  rb[64];

  task automatic chk(input string nm, input logic [69:0] act,
                     input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM responder: writes via DUT byte enables, garbage when idle
  always @(posedge clk) begin
    logic [31:0] w;
    if (data_sram_en) begin
      w = sram[data_sram_addr[5:2]];
      for (int i = 0; i < 4; i++)
        if (data_sram_we[i]) w[8*i +: 8] = data_sram_wdata[8*i +: 8];
      sram[data_sram_addr[5:2]] <= w;
      data_sram_rdata <= (|data_sram_we) ? $urandom : w;
    end else begin
      data_sram_rdata <= $urandom;
    end
  end

  function automatic logic next_wb();
    if (force_stall > 0) begin
      force_stall--;
      return 1'b0;
    end
    return $urandom_range(99) >= stall_pct;
  endfunction

  function automatic logic [106:0] mk(
    input logic [31:0] pc, input logic [31:0] alu,
    input logic [31:0] rkd, input logic [4:0] dest,
    input logic gr_we, input logic rfm, input logic mwe,
    input logic [1:0] size, input logic uns);
    return {pc, alu, rkd, dest, gr_we, rfm, mwe, size, uns};
  endfunction

  task automatic put_word(input int idx, input logic [31:0] v);
    sram[idx] = v;
    for (int i = 0; i < 4; i++) rb[idx*4 + i] = v[8*i +: 8];
  endtask

  // Reference: expected SRAM request and WB result for an accepted op
  task automatic on_accept(input logic [106:0] b);
    logic [31:0] pc, alu, rkd, res, wd;
    logic [4:0]  dest;
    logic        gr_we, rfm, mwe, uns;
    logic [1:0]  size;
    logic [5:0]  base;
    logic [3:0]  mask;
    int          nb;
    exp_t        e;
    {pc, alu, rkd, dest, gr_we, rfm, mwe, size, uns} = b;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = alu[5:0] & ~(6'(nb - 1));
    chk("sram_en", 70'(data_sram_en), 70'(rfm | mwe));
    if (rfm | mwe) chk("sram_addr", 70'(data_sram_addr), 70'(alu));
    mask = 4'b0;
    if (mwe)
      for (int i = 0; i < 4; i++)
        mask[i] = (i >= int'(base[1:0])) && (i < int'(base[1:0]) + nb);
    chk("sram_we", 70'(data_sram_we), 70'(mask));
    if (mwe) begin
      wd = (nb == 1) ? {4{rkd[7:0]}} :
           (nb == 2) ? {2{rkd[15:0]}} : rkd;
      chk("sram_wdata", 70'(data_sram_wdata), 70'(wd));
      for (int i = 0; i < nb; i++) rb[base + 6'(i)] = rkd[8*i +: 8];
    end
    res = alu;
    if (rfm) begin
      res = 32'h0;
      for (int i = 0; i < nb; i++) res[8*i +: 8] = rb[base + 6'(i)];
      if (!uns && nb == 1 && res[7])  res = res | 32'hFFFF_FF00;
      if (!uns && nb == 2 && res[15]) res = res | 32'hFFFF_0000;
    end
    e.wb = {pc, res, dest, gr_we};
    e.is_load = rfm;
    e.dest = gr_we ? dest : 5'd0;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [106:0] b);
    logic acc;
    EX_to_MEM_valid = 1'b1;
    to_MEM_data = b;
    for (int n = 0; n < 200; n++) begin
      #4;
      acc = MEM_allow_in & ~reset;
      if (acc) on_accept(b);
      else begin
        chk("stall_en", 70'(data_sram_en), 70'(0));
        chk("stall_we", 70'(data_sram_we), 70'(0));
      end
      @(negedge clk);
      WB_allow_in = next_wb();
      if (acc) break;
      if (n == 199) chk("accept_timeout", 70'(0), 70'(1));
    end
    EX_to_MEM_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    EX_to_MEM_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      WB_allow_in = next_wb();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!reset) begin
      if (MEM_to_WB_valid) begin
        if (q.size() == 0) chk("spurious_valid", 70'(1), 70'(0));
        else begin
          e = q[0];
          chk("is_load", 70'(MEM_is_load), 70'(e.is_load));
          chk("mem_dest", 70'(MEM_dest), 70'(e.dest));
          if (WB_allow_in) begin
            chk("to_wb", to_WB_data, e.wb);
            chk("fwd_data", 70'(MEM_fwd_data), 70'(e.wb[37:6]));
            void'(q.pop_front());
          end
        end
      end else begin
        chk("idle_dest", 70'(MEM_dest), 70'(0));
        chk("idle_load", 70'(MEM_is_load), 70'(0));
      end
    end
  end

  initial begin
    logic [106:0] b;
    reset = 1'b1;
    EX_to_MEM_valid = 1'b0;
    to_MEM_data = '0;
    WB_allow_in = 1'b1;
    data_sram_rdata = 32'h0;
    for (int i = 0; i < 16; i++) put_word(i, $urandom);
    put_word(4, 32'h8012_3456);
    put_word(0, 32'hFFFF_0000);
    repeat (2) @(negedge clk);
    #4;
    chk("rst_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("rst_dest", 70'(MEM_dest), 70'(0));
    chk("rst_pc", 70'(to_WB_data[69:38]), 70'(RPC));
    @(negedge clk);
    reset = 1'b0;
    // ld.b, st.h, ALU op
    send(mk(32'h100, 32'h1C00_0013, 32'h0, 5'd3, 1, 1, 0, 2'd0, 0));
    idle(2);
    send(mk(32'h104, 32'h0000_0002, 32'h1234_ABCD, 5'd0, 0, 0, 1, 2'd1, 0));
    send(mk(32'h108, 32'h0000_0007, 32'h0, 5'd5, 1, 0, 0, 2'd2, 0));
    idle(1);
    // ld.w with three stall cycles
    force_stall = 3;
    send(mk(32'h10C, 32'h0000_0010, 32'h0, 5'd7, 1, 1, 0, 2'd2, 0));
    idle(5);
    // back-to-back add, ld.hu, add
    put_word(0, 32'hFFFF_0000);
    send(mk(32'h110, 32'h11, 32'h0, 5'd1, 1, 0, 0, 2'd2, 0));
    send(mk(32'h114, 32'h02, 32'h0, 5'd2, 1, 1, 0, 2'd1, 1));
    send(mk(32'h118, 32'h33, 32'h0, 5'd4, 1, 0, 0, 2'd2, 0));
    idle(2);
    // reset during a stalled st.b
    force_stall = 10;
    send(mk(32'h11C, 32'h05, 32'hA5, 5'd0, 0, 0, 1, 2'd0, 0));
    b = mk(32'h120, 32'h08, 32'h5A, 5'd0, 0, 0, 1, 2'd2, 0);
    EX_to_MEM_valid = 1'b1;
    to_MEM_data = b;
    reset = 1'b1;
    #4;
    chk("rst_stall_en", 70'(data_sram_en), 70'(0));
    chk("rst_stall_we", 70'(data_sram_we), 70'(0));
    @(negedge clk);
    #4;
    chk("rst_gate_en", 70'(data_sram_en), 70'(0));
    chk("rst_gate_we", 70'(data_sram_we), 70'(0));
    chk("rst2_valid", 70'(MEM_to_WB_valid), 70'(0));
    chk("rst2_dest", 70'(MEM_dest), 70'(0));
    @(negedge clk);
    reset = 1'b0;
    force_stall = 0;
    EX_to_MEM_valid = 1'b0;
    WB_allow_in = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) rb[i*4 + j] = sram[i][8*j +: 8];
    #4;
    chk("post_rst_pc", 70'(to_WB_data[69:38]), 70'(RPC));
    @(negedge clk);
    send(mk(32'h200, 32'h0C, 32'h0, 5'd9, 1, 1, 0, 2'd2, 0));
    idle(2);
    // randomized traffic with back-pressure
    stall_pct = 30;
    for (int t = 0; t < 400; t++) begin
      int op;
      logic [31:0] alu;
      op = $urandom_range(2);
      alu = $urandom;
      case (op)
        0: b = mk($urandom, alu, $urandom, 5'($urandom), 1, 0, 0,
                  2'($urandom), 1'($urandom));
        1: b = mk($urandom, alu, $urandom, 5'($urandom), 1, 1, 0,
                  2'($urandom), 1'($urandom));
        default: b = mk($urandom, alu, $urandom, 5'($urandom), 0, 0, 1,
                        2'($urandom), 1'($urandom));
      endcase
      send(b);
      if ($urandom_range(3) == 0) idle($urandom_range(2));
    end
    stall_pct = 0;
    idle(6);
    chk("drain", 70'(q.size()), 70'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
